drbg_out_buffer: RTL

DRBG_OUT_BUFFER -- requirements
Module: drbg_out_buffer

---
 rtl/drbg_out_buffer.sv | 98 +++++++++
 1 files changed

// File: rtl/drbg_out_buffer.sv
// drbg_out_buffer: FIFO of 128-bit DRBG blocks serialized to 32-bit words,
// with a refill FSM that requests more blocks when enough space is free.
module drbg_out_buffer #(
    parameter int DEPTH         = 4,
    parameter int REFILL_BLOCKS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable_i,
    input  logic                       flush_i,
    input  logic                       drbg_busy_i,
    input  logic                       drbg_done_i,
    input  logic                       drbg_valid_i,
    input  logic [127:0]               drbg_block_i,
    output logic                       drbg_generate_o,
    output logic [15:0]                drbg_num_blocks_o,
    output logic                       word_valid_o,
    input  logic                       word_ready_i,
    output logic [31:0]                word_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state_q, state_d;
    logic [127:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [1:0]      idx_q, idx_d;
    logic            overflow_q, overflow_d;
    logic [127:0]    head;
    logic            fire, pop, full, push, drop, can_req;

    assign head    = mem_q[rd_ptr_q];
    assign fire    = word_valid_o && word_ready_i;
    assign pop     = fire && idx_q == 2'd3;
    assign full    = level_q == LW'(DEPTH);
    // A full FIFO still accepts a block when the head leaves in the same cycle.
    assign push    = drbg_valid_i && !flush_i && (!full || pop);
    assign drop    = drbg_valid_i && !flush_i && full && !pop;
    assign can_req = int'(level_q) <= DEPTH - REFILL_BLOCKS;

    always_comb begin
        wr_ptr_d   = flush_i ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d   = flush_i ? '0 : rd_ptr_q + AW'(pop);
        level_d    = flush_i ? '0 : level_q + LW'(push) - LW'(pop);
        idx_d      = flush_i ? '0 : idx_q + 2'(fire);
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: word_o is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= drbg_block_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (enable_i && !drbg_busy_i && can_req && !flush_i) ? REQ : IDLE;
            REQ:     state_d = WAIT;
            WAIT:    state_d = drbg_done_i ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drbg_generate_o   = state_q == REQ;
        drbg_num_blocks_o = 16'(REFILL_BLOCKS);
        word_valid_o      = level_q != '0;
        word_o            = word_valid_o ? head[{~idx_q, 5'd0} +: 32] : '0;
        level_o           = level_q;
        overflow_o        = overflow_q;
    end
endmodule
